// File: rtl/jpeg_quantizer_pkg.sv
// jpeg_quant_pkg: default reciprocal tables, zigzag-to-raster map and component type.
package jpeg_quant_pkg;
   typedef enum logic [1:0] {Y = 2'd0, CB = 2'd1, CR = 2'd2} comp_t;
   typedef logic [0:63][7:0]  q_tbl_t;
   typedef logic [0:63][12:0] recip_tbl_t;
   typedef logic [0:63][5:0]  zz_tbl_t;
   localparam q_tbl_t LUMA_Q = '{
      16, 11, 10, 16, 24, 40, 51, 61,
      12, 12, 14, 19, 26, 58, 60, 55,
      14, 13, 16, 24, 40, 57, 69, 56,
      14, 17, 22, 29, 51, 87, 80, 62,
      18, 22, 37, 56, 68, 109, 103, 77,
      24, 35, 55, 64, 81, 104, 113, 92,
      49, 64, 78, 87, 103, 121, 120, 101,
      72, 92, 95, 98, 112, 100, 103, 99};
   localparam q_tbl_t CHROMA_Q = '{
      17, 18, 24, 47, 99, 99, 99, 99,
      18, 21, 26, 66, 99, 99, 99, 99,
      24, 26, 56, 99, 99, 99, 99, 99,
      47, 66, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99};
   localparam zz_tbl_t ZZ_TO_RASTER = '{
      0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
   function automatic recip_tbl_t to_recip(q_tbl_t q);
      recip_tbl_t r;
      for (int i = 0; i < 64; i++) r[i] = 13'(4096 / int'(q[i]));
      return r;
   endfunction
   localparam recip_tbl_t LUMA_RECIP   = to_recip(LUMA_Q);
   localparam recip_tbl_t CHROMA_RECIP = to_recip(CHROMA_Q);
endpackage

// File: rtl/jpeg_quantizer_if.sv
// jpeg_quantizer_if: coefficient stream in, quantized stream out, table config port.
interface jpeg_quantizer_if #(
   parameter int COEF_W  = 11,
   parameter int OUT_W   = 11,
   parameter int RECIP_W = 13
);
   logic                      in_valid, in_ready, in_sob;
   logic signed [COEF_W-1:0]  in_data;
   logic [1:0]                in_comp;
   logic                      out_valid, out_ready, out_sob, out_eob;
   logic signed [OUT_W-1:0]   out_data;
   logic [1:0]                out_comp;
   logic                      cfg_we, cfg_tbl, cfg_err, sync_err;
   logic [5:0]                cfg_addr;
   logic [RECIP_W-1:0]        cfg_data;
   modport master (
      output in_valid, in_data, in_sob, in_comp, out_ready, cfg_we, cfg_tbl, cfg_addr, cfg_data,
      input  in_ready, out_valid, out_data, out_sob, out_eob, out_comp, cfg_err, sync_err
   );
   modport slave (
      input  in_valid, in_data, in_sob, in_comp, out_ready, cfg_we, cfg_tbl, cfg_addr, cfg_data,
      output in_ready, out_valid, out_data, out_sob, out_eob, out_comp, cfg_err, sync_err
   );
endinterface

// File: rtl/jpeg_quantizer_recip_table.sv
// quant_recip_table: luma/chroma reciprocal tables with reset defaults, write port, registered read.
module quant_recip_table
   import jpeg_quant_pkg::*;
#(
   parameter int RECIP_W = 13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_re,
   input  logic               i_rtbl,
   input  logic [5:0]         i_raddr,
   output logic [RECIP_W-1:0] o_recip,
   input  logic               i_we,
   input  logic               i_wtbl,
   input  logic [5:0]         i_waddr,
   input  logic [RECIP_W-1:0] i_wdata
);
   logic [RECIP_W-1:0] r_luma [64];
   logic [RECIP_W-1:0] r_chroma [64];
   logic [RECIP_W-1:0] r_recip;
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 64; i++) begin
            r_luma[i]   <= RECIP_W'(LUMA_RECIP[i]);
            r_chroma[i] <= RECIP_W'(CHROMA_RECIP[i]);
         end
         r_recip <= '0;
      end else begin
         if (i_we & ~i_wtbl) r_luma[i_waddr] <= i_wdata;
         if (i_we & i_wtbl) r_chroma[i_waddr] <= i_wdata;
         if (i_re) r_recip <= i_rtbl ? r_chroma[i_raddr] : r_luma[i_raddr];
      end
   end
   assign o_recip = r_recip;
endmodule

// File: rtl/jpeg_quantizer.sv
// jpeg_quantizer: streaming 3-stage reciprocal-multiply quantizer with round-half-up and saturation.
module jpeg_quantizer
   import jpeg_quant_pkg::*;
#(
   parameter int COEF_W  = 11,
   parameter int OUT_W   = 11,
   parameter int RECIP_W = 13,
   parameter int FRAC    = 12,
   parameter int ZIGZAG  = 0
) (
   input logic             clk,
   input logic             rst,
   jpeg_quantizer_if.slave bus
);
   localparam int PW = COEF_W + RECIP_W + 1;
   localparam int RW = PW - FRAC + 1;
   localparam logic signed [RW-1:0] MAXV = RW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [RW-1:0] MINV = ~MAXV;
   logic                     w_adv, w_acc, w_cfg_ok;
   logic [5:0]               w_idx, w_pos;
   logic [1:0]               w_comp;
   logic [RECIP_W-1:0]       w_recip;
   logic signed [RW-1:0]     w_r;
   logic signed [OUT_W-1:0]  w_sat;
   logic [5:0]               r_idx;
   logic [1:0]               r_comp, r_comp0, r_comp1, r_ocomp;
   logic                     r_v0, r_sob0, r_eob0, r_v1, r_sob1, r_eob1, r_ov, r_osob, r_oeob;
   logic signed [COEF_W-1:0] r_d0;
   logic signed [PW-1:0]     r_p1;
   logic signed [OUT_W-1:0]  r_odata;
   logic                     r_cfg_err, r_sync_err;
   assign w_adv    = ~r_ov | bus.out_ready;
   assign w_acc    = bus.in_valid & bus.in_ready;
   assign w_idx    = bus.in_sob ? 6'd0 : r_idx;
   assign w_pos    = ZIGZAG != 0 ? ZZ_TO_RASTER[w_idx] : w_idx;
   assign w_comp   = w_idx == 6'd0 ? bus.in_comp : r_comp;
   // tables may only change between blocks, never under an accepted beat
   assign w_cfg_ok = r_idx == 6'd0 & ~w_acc;
   assign w_r      = RW'(r_p1 >>> FRAC) + RW'(r_p1[FRAC-1]);
   assign w_sat    = w_r > MAXV ? OUT_W'(MAXV) : w_r < MINV ? OUT_W'(MINV) : OUT_W'(w_r);
   quant_recip_table #(.RECIP_W(RECIP_W)) u_tbl (
      .clk     (clk),
      .rst     (rst),
      .i_re    (w_acc),
      .i_rtbl  (w_comp != Y),
      .i_raddr (w_pos),
      .o_recip (w_recip),
      .i_we    (bus.cfg_we & w_cfg_ok),
      .i_wtbl  (bus.cfg_tbl),
      .i_waddr (bus.cfg_addr),
      .i_wdata (bus.cfg_data)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_idx <= '0; r_comp <= '0;
         r_v0 <= 1'b0; r_d0 <= '0; r_sob0 <= 1'b0; r_eob0 <= 1'b0; r_comp0 <= '0;
         r_v1 <= 1'b0; r_p1 <= '0; r_sob1 <= 1'b0; r_eob1 <= 1'b0; r_comp1 <= '0;
         r_ov <= 1'b0; r_odata <= '0; r_osob <= 1'b0; r_oeob <= 1'b0; r_ocomp <= '0;
         r_cfg_err <= 1'b0; r_sync_err <= 1'b0;
      end else begin
         r_cfg_err  <= bus.cfg_we & ~w_cfg_ok;
         r_sync_err <= w_acc & bus.in_sob & (r_idx != 6'd0);
         if (w_acc) begin
            r_idx  <= w_idx + 6'd1;
            r_comp <= w_comp;
         end
         if (w_adv) begin
            r_v0    <= w_acc;
            r_d0    <= bus.in_data;
            r_sob0  <= w_idx == 6'd0;
            r_eob0  <= w_idx == 6'd63;
            r_comp0 <= w_comp;
            r_v1    <= r_v0;
            r_p1    <= PW'(r_d0) * PW'($signed({1'b0, w_recip}));
            r_sob1  <= r_sob0;
            r_eob1  <= r_eob0;
            r_comp1 <= r_comp0;
            r_ov    <= r_v1;
            r_odata <= w_sat;
            r_osob  <= r_v1 & r_sob1;
            r_oeob  <= r_v1 & r_eob1;
            r_ocomp <= r_comp1;
         end
      end
   end
   assign bus.in_ready  = rst & w_adv;
   assign bus.out_valid = r_ov;
   assign bus.out_data  = r_odata;
   assign bus.out_sob   = r_osob;
   assign bus.out_eob   = r_oeob;
   assign bus.out_comp  = r_ocomp;
   assign bus.cfg_err   = r_cfg_err;
   assign bus.sync_err  = r_sync_err;
endmodule

// File: tb/tb_jpeg_quantizer.sv
// tb_jpeg_quantizer: raster and zigzag instances on shared stimulus, scoreboarded against an arithmetic model.
module tb_jpeg_quantizer;
   typedef struct {int d; bit s; bit e; int c;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   jpeg_quantizer_if #(.COEF_W(11), .OUT_W(11), .RECIP_W(13)) ifa ();
   jpeg_quantizer_if #(.COEF_W(11), .OUT_W(11), .RECIP_W(13)) ifz ();
   jpeg_quantizer #(.ZIGZAG(0)) dut_r (.clk(clk), .rst(rst), .bus(ifa));
   jpeg_quantizer #(.ZIGZAG(1)) dut_z (.clk(clk), .rst(rst), .bus(ifz));
   assign ifz.in_valid  = ifa.in_valid;
   assign ifz.in_data   = ifa.in_data;
   assign ifz.in_sob    = ifa.in_sob;
   assign ifz.in_comp   = ifa.in_comp;
   assign ifz.out_ready = ifa.out_ready;
   assign ifz.cfg_we    = ifa.cfg_we;
   assign ifz.cfg_tbl   = ifa.cfg_tbl;
   assign ifz.cfg_addr  = ifa.cfg_addr;
   assign ifz.cfg_data  = ifa.cfg_data;
   int total = 0, bad = 0;
   exp_t q0[$], q1[$];
   int tbl[2][64];
   int zz[64];
   int m_idx, m_comp, stall;
   bit exp_cfg, exp_sync, bp;
   int lq[64] = '{16, 11, 10, 16, 24, 40, 51, 61, 12, 12, 14, 19, 26, 58, 60, 55,
                  14, 13, 16, 24, 40, 57, 69, 56, 14, 17, 22, 29, 51, 87, 80, 62,
                  18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
                  49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
   int cq[64] = '{17, 18, 24, 47, 99, 99, 99, 99, 18, 21, 26, 66, 99, 99, 99, 99,
                  24, 26, 56, 99, 99, 99, 99, 99, 47, 66, 99, 99, 99, 99, 99, 99,
                  99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99,
                  99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99, 99};
   task automatic chk(string n, longint a, longint e);
      total++;
      if (a != e) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask
   function automatic int quant(int x, int rc);
      longint r = (longint'(x) * rc + 2048) >>> 12;
      return int'(r > 1023 ? 1023 : r < -1024 ? -1024 : r);
   endfunction
   function automatic int rnd();
      return int'($urandom_range(0, 2047)) - 1024;
   endfunction
   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         tbl[0][i] = 4096 / lq[i];
         tbl[1][i] = 4096 / cq[i];
      end
      m_idx = 0; m_comp = 0; exp_cfg = 0; exp_sync = 0;
      q0.delete(); q1.delete();
   endtask
   task automatic check_pulses();
      chk("cfg_err", ifa.cfg_err, exp_cfg);
      chk("sync_err", ifa.sync_err, exp_sync);
      chk("cfg_err_zz", ifz.cfg_err, exp_cfg);
      chk("sync_err_zz", ifz.sync_err, exp_sync);
   endtask
   task automatic cyc(input bit v, input int d, input bit sob, input int comp,
                      input bit we, input bit ts, input int addr, input int wd, output bit acc);
      int k;
      @(negedge clk);
      check_pulses();
      ifa.in_valid = v; ifa.in_data = 11'(d); ifa.in_sob = sob; ifa.in_comp = 2'(comp);
      ifa.cfg_we = we; ifa.cfg_tbl = ts; ifa.cfg_addr = 6'(addr); ifa.cfg_data = 13'(wd);
      if (stall > 0) begin
         ifa.out_ready = 1'b0;
         stall--;
      end else ifa.out_ready = !bp || $urandom_range(0, 3) != 0;
      #1;
      if (ifa.out_valid && !ifa.out_ready) chk("in_ready_stall", ifa.in_ready, 0);
      acc = v && ifa.in_ready;
      exp_cfg = we && !(m_idx == 0 && !acc);
      if (we && !exp_cfg) tbl[ts][addr] = wd & 8191;
      exp_sync = acc && sob && m_idx != 0;
      if (acc) begin
         k = sob ? 0 : m_idx;
         if (k == 0) m_comp = comp;
         q0.push_back('{quant(d, tbl[m_comp != 0][k]), k == 0, k == 63, m_comp});
         q1.push_back('{quant(d, tbl[m_comp != 0][zz[k]]), k == 0, k == 63, m_comp});
         m_idx = (k + 1) % 64;
      end
   endtask
   task automatic idle(int n);
      bit a;
      repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, a);
   endtask
   task automatic cfg(bit ts, int addr, int wd);
      bit a;
      cyc(0, 0, 0, 0, 1, ts, addr, wd, a);
   endtask
   task automatic beat(int d, bit sob, int comp);
      bit a = 0;
      int n = 0;
      if (bp && $urandom_range(0, 5) == 0) idle(1);
      while (!a && n < 40) begin
         cyc(1, d, sob, comp, 0, 0, 0, 0, a);
         n++;
      end
      if (!a) chk("beat_accept_timeout", 0, 1);
   endtask
   task automatic block(int first, int comp, int kind);
      beat(first, 1, comp);
      for (int i = 1; i < 64; i++)
         beat(kind == 1 ? i : kind == 2 ? (i == 2 ? 1023 : 0) : rnd(), 0, comp);
   endtask
   task automatic do_reset(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_pulses();
         rst = 1'b0;
         ifa.in_valid = 0; ifa.in_sob = 0; ifa.cfg_we = 0; ifa.out_ready = 1;
         #1;
         chk("in_ready_in_reset", ifa.in_ready, 0);
         model_reset();
      end
      @(negedge clk);
      check_pulses();
      chk("rst_out_valid", ifa.out_valid, 0);
      chk("rst_out_data", ifa.out_data, 0);
      chk("rst_out_sob", ifa.out_sob, 0);
      chk("rst_out_eob", ifa.out_eob, 0);
      chk("rst_out_comp", ifa.out_comp, 0);
      chk("rst_out_valid_zz", ifz.out_valid, 0);
      rst = 1'b1;
      #1;
      chk("in_ready_after_reset", ifa.in_ready, 1);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst && ifa.out_valid) begin
            if (q0.size() == 0) chk("raster_unexpected_output", 1, 0);
            else begin
               e = q0[0];
               chk("raster_data", ifa.out_data, e.d);
               chk("raster_sob", ifa.out_sob, e.s);
               chk("raster_eob", ifa.out_eob, e.e);
               chk("raster_comp", ifa.out_comp, e.c);
               if (ifa.out_ready) void'(q0.pop_front());
            end
         end
         if (rst && ifz.out_valid) begin
            if (q1.size() == 0) chk("zz_unexpected_output", 1, 0);
            else begin
               e = q1[0];
               chk("zz_data", ifz.out_data, e.d);
               chk("zz_sob", ifz.out_sob, e.s);
               chk("zz_eob", ifz.out_eob, e.e);
               chk("zz_comp", ifz.out_comp, e.c);
               if (ifz.out_ready) void'(q1.pop_front());
            end
         end
      end
   end
   initial begin
      int n, r, c;
      ifa.in_valid = 0; ifa.in_data = 0; ifa.in_sob = 0; ifa.in_comp = 0; ifa.out_ready = 1;
      ifa.cfg_we = 0; ifa.cfg_tbl = 0; ifa.cfg_addr = 0; ifa.cfg_data = 0;
      n = 0;
      for (int s = 0; s < 15; s++)
         for (int j = 0; j < 8; j++) begin
            r = (s % 2 == 0) ? 7 - j : j;
            c = s - r;
            if (c >= 0 && c < 8) begin
               zz[n] = r * 8 + c;
               n++;
            end
         end
      bp = 0; stall = 0;
      model_reset();
      do_reset(3);
      beat(1023, 1, 0);
      idle(1); chk("latency_cycle1", ifa.out_valid, 0);
      idle(1); chk("latency_cycle2", ifa.out_valid, 0);
      idle(1); chk("latency_cycle3", ifa.out_valid, 1);
      for (int i = 1; i < 64; i++) beat(rnd(), 0, 0);
      block(-1024, 0, 0);
      block(1023, 1, 0);
      bp = 1;
      block(0, 2, 1);
      bp = 0;
      cfg(0, 0, 8191);
      block(1023, 0, 0);
      block(-1024, 0, 0);
      beat(rnd(), 1, 1);
      for (int i = 1; i < 64; i++) begin
         if (i == 10) stall = 5;
         beat(rnd(), 0, 1);
      end
      beat(rnd(), 1, 0);
      for (int i = 1; i < 20; i++) beat(rnd(), 0, 0);
      cfg(0, 5, 1);
      block(1023, 0, 0);
      block(0, 0, 2);
      bp = 1;
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 19));
         if (r == 0) cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), int'($urandom_range(1, 8191)));
         else beat(rnd(), r == 1, int'($urandom_range(0, 3)));
      end
      bp = 0;
      for (int i = 0; i < 30; i++) beat(rnd(), i == 0, 2);
      do_reset(2);
      block(1023, 0, 0);
      for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) idle(1);
      chk("drain_raster", q0.size(), 0);
      chk("drain_zz", q1.size(), 0);
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/jpeg_quantizer.md
# jpeg_quantizer

Streaming, parametrised JPEG quantizer that replaces the fixed per-component 8x8 parallel quantizers. It accepts DCT coefficients one per cycle with valid/ready flow control and selects the luma or chroma table per block. It multiplies each coefficient by a runtime-loadable fixed-point reciprocal, then rounds and saturates the result. It sits between the DCT stage and the zigzag/entropy stage.

## Interface
- COEF_W, 11: signed input coefficient width
- OUT_W, 11: signed output width; the result saturates to this width
- RECIP_W, 13: unsigned reciprocal width, covering floor(4096/1) = 4096
- FRAC, 12: fractional bits of the reciprocal
- ZIGZAG, 0: input order; 0 = raster (row*8+col), 1 = zigzag scan order

Ports:
- clk, in, 1: clock
- rst, in, 1: reset; one clock; synchronous, active-low (0 = reset)
- in_valid, in, 1: coefficient valid
- in_ready, out, 1: coefficient accepted when in_valid & in_ready
- in_data, in, COEF_W: signed coefficient
- in_sob, in, 1: first coefficient of an 8x8 block
- in_comp, in, 2: 0 = Y (luma table), 1 = Cb, 2 = Cr (chroma table), 3 = reserved (treated as chroma); sampled on the accepted sob beat
- out_valid, out, 1: result valid
- out_ready, in, 1: downstream accept
- out_data, out, OUT_W: quantized coefficient
- out_sob, out, 1: marks the first result of a block
- out_eob, out, 1: marks the 64th result of a block
- out_comp, out, 2: component of the block
- cfg_we, in, 1: table write strobe
- cfg_tbl, in, 1: 0 = luma, 1 = chroma
- cfg_addr, in, 6: raster position
- cfg_data, in, RECIP_W: reciprocal value
- cfg_err, out, 1: one-cycle pulse when a write is rejected
- sync_err, out, 1: one-cycle pulse on a block realignment

## Operation
- Index counter idx runs 0..63 and advances on each accepted beat.
  - An accepted beat with in_sob forces that beat to idx 0.
  - If in_sob arrives while idx != 0, the block realigns to idx 0 and sync_err pulses. The partial block's out_eob is never emitted.
- Table position: pos = idx when ZIGZAG=0, else ZZ_TO_RASTER[idx].
- Component/table select is latched at idx 0 and held for the whole block.
- Two 64-entry reciprocal tables (luma, chroma). Reset loads floor(4096/Q) of the standard Annex K.1 (luma) and K.2 (chroma) tables.
- Arithmetic:
  - p = in_data * signed({1'b0, recip}); width COEF_W+RECIP_W+1.
  - r = (p >>> FRAC) + p[FRAC-1], which rounds half up.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Config writes:
  - A write is applied only when idx == 0 and no beat is accepted that cycle. The new value is visible from the next accepted beat.
  - Otherwise the write is dropped and cfg_err pulses.
  - A write on the same cycle as an accepted first coefficient is rejected. That coefficient uses the old value.
- Reset mid-block clears idx, the pipeline valids, the error pulses, and the tables to default. Any partial output is discarded.

## Timing
- Three-stage pipeline:
  - S0: register the beat and read the table.
  - S1: multiply.
  - S2: round, saturate, and drive the outputs.
- Latency is 3 cycles from input acceptance to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Stall-all flow control: advance = ~out_valid | out_ready, and in_ready = advance.
- out_data, out_sob, out_eob and out_comp hold stable while out_valid & ~out_ready.
- Reset values:
  - in_ready = 0 during reset and 1 after reset.
  - out_valid, out_sob, out_eob, cfg_err and sync_err = 0.
  - out_data = 0 and out_comp = 0.

## Structure
- Package jpeg_quant_pkg holds:
  - the default reciprocal tables LUMA_RECIP and CHROMA_RECIP;
  - the ZZ_TO_RASTER LUT;
  - the comp_t enum (Y, CB, CR).
- Sub-module quant_recip_table contains both 64-entry tables, the reset-default load, the write port, and the registered read.

## Test plan
- Default luma table, in_sob with in_data = 1023 at idx 0 -> out_data = 64, with out_sob. The same block with in_data = -1024 at idx 0 -> out_data = -64.
- Default chroma table (in_comp = 1), in_data = 1023 at idx 0 -> out_data = 60. A 64-beat ramp 0..63 produces a matching reference model output, with out_eob on the 64th result only.
- Write cfg_data = 8191 to luma position 0 while idle, then stream in_data = 1023 -> out_data = 1023 (saturated). With in_data = -1024 -> out_data = -1024.
- Hold out_ready = 0 for 5 cycles during a block -> in_ready drops, and outputs hold stable. No beat is lost or duplicated, and the order across the stall is preserved.
- Assert in_sob at idx 20 -> sync_err pulses, and the next result carries out_sob. A cfg_we at idx 20 -> cfg_err pulses and the table is unchanged.
- ZIGZAG = 1 instance with an impulse at idx 2 -> the result is scaled by raster position 8 (luma Q = 12, recip 341): in_data = 1023 -> out_data = 85.
